// File: rtl/apb_req_arb.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Each grant runs a full SETUP/ACCESS/DONE transfer; stalled slaves are aborted after TIMEOUT waits.
module apb_req_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_done,
  output logic [31:0] req_rdata,
  output logic        req_err,
  output logic [15:0] apb_addr,
  output logic        apb_selx,
  output logic        apb_enable,
  output logic        apb_write,
  output logic [31:0] apb_wdata,
  input  logic        apb_ready,
  input  logic [31:0] apb_rdata,
  input  logic        apb_slverr,
  output logic        busy,
  output logic [7:0]  tmo_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last not-ready cycle before the transfer is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  logic        grant_r;
  logic        last_r;
  logic [7:0]  wait_r;

  logic        win_s;
  logic [15:0] sel_addr_s;
  logic        sel_write_s;
  logic [31:0] sel_wdata_s;

  // Round-robin pick: a tie goes to the requester not served last.
  always_comb begin
    win_s = 1'b0;
    if (req_valid == 2'b11) begin
      win_s = ~last_r;
    end else if (req_valid[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Select the winning requester's transfer fields.
  always_comb begin
    sel_addr_s  = req_addr[15:0];
    sel_write_s = req_write[0];
    sel_wdata_s = req_wdata[31:0];
    if (win_s) begin
      sel_addr_s  = req_addr[31:16];
      sel_write_s = req_write[1];
      sel_wdata_s = req_wdata[63:32];
    end else begin
      sel_addr_s  = req_addr[15:0];
      sel_write_s = req_write[0];
      sel_wdata_s = req_wdata[31:0];
    end
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant_r    <= 1'b0;
      last_r     <= 1'b1;
      wait_r     <= 8'd0;
      req_done   <= 2'b00;
      req_rdata  <= 32'd0;
      req_err    <= 1'b0;
      apb_addr   <= 16'd0;
      apb_selx   <= 1'b0;
      apb_enable <= 1'b0;
      apb_write  <= 1'b0;
      apb_wdata  <= 32'd0;
      busy       <= 1'b0;
      tmo_cnt    <= 8'd0;
    end else begin
      req_done <= 2'b00;
      case (state_r)
        IDLE: begin
          if (|req_valid) begin
            grant_r   <= win_s;
            last_r    <= win_s;
            apb_addr  <= sel_addr_s;
            apb_write <= sel_write_s;
            apb_wdata <= sel_wdata_s;
            apb_selx  <= 1'b1;
            busy      <= 1'b1;
            state_r   <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          apb_enable <= 1'b1;
          state_r    <= ACCESS;
        end
        ACCESS: begin
          if (apb_ready) begin
            req_rdata  <= apb_write ? 32'd0 : apb_rdata;
            req_err    <= apb_slverr;
            wait_r     <= 8'd0;
            req_done   <= grant_r ? 2'b10 : 2'b01;
            apb_selx   <= 1'b0;
            apb_enable <= 1'b0;
            state_r    <= DONE;
          end else if (wait_r == TMO_LAST) begin
            req_rdata  <= 32'd0;
            req_err    <= 1'b1;
            wait_r     <= 8'd0;
            req_done   <= grant_r ? 2'b10 : 2'b01;
            apb_selx   <= 1'b0;
            apb_enable <= 1'b0;
            if (tmo_cnt != 8'hFF) begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end else begin
              tmo_cnt <= tmo_cnt;
            end
            state_r <= DONE;
          end else begin
            wait_r <= wait_r + 8'd1;
          end
        end
        DONE: begin
          apb_selx   <= 1'b0;
          apb_enable <= 1'b0;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          apb_selx   <= 1'b0;
          apb_enable <= 1'b0;
          busy       <= 1'b0;
          wait_r     <= 8'd0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  apb_req_arb_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_done   (req_done),
    .apb_selx   (apb_selx),
    .apb_enable (apb_enable),
    .busy       (busy)
  );

endmodule

// Protocol invariants of the arbiter's outputs.
module apb_req_arb_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] req_done,
  input logic       apb_selx,
  input logic       apb_enable,
  input logic       busy
);

  a_en_needs_sel: assert property (@(posedge clk) disable iff (!rst_n)
    apb_enable |-> apb_selx);

  a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_done));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    (|req_done) |=> (req_done == 2'b00));

  a_done_no_sel: assert property (@(posedge clk) disable iff (!rst_n)
    (|req_done) |-> !apb_selx);

  a_sel_busy: assert property (@(posedge clk) disable iff (!rst_n)
    apb_selx |-> busy);

endmodule

// File: tb/tb_apb_req_arb.sv
// Randomized bench for apb_req_arb: a transaction-level model predicts grant order,
// phase lengths and responses; every cycle of every transfer is compared.
module tb_apb_req_arb;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_addr;
  logic [1:0]  req_write;
  logic [63:0] req_wdata;
  logic [1:0]  req_done;
  logic [31:0] req_rdata;
  logic        req_err;
  logic [15:0] apb_addr;
  logic        apb_selx;
  logic        apb_enable;
  logic        apb_write;
  logic [31:0] apb_wdata;
  logic        apb_ready;
  logic [31:0] apb_rdata;
  logic        apb_slverr;
  logic        busy;
  logic [7:0]  tmo_cnt;

  apb_req_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_done   (req_done),
    .req_rdata  (req_rdata),
    .req_err    (req_err),
    .apb_addr   (apb_addr),
    .apb_selx   (apb_selx),
    .apb_enable (apb_enable),
    .apb_write  (apb_write),
    .apb_wdata  (apb_wdata),
    .apb_ready  (apb_ready),
    .apb_rdata  (apb_rdata),
    .apb_slverr (apb_slverr),
    .busy       (busy),
    .tmo_cnt    (tmo_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester model
  logic [1:0]  pend;
  logic [15:0] a  [2];
  logic        w  [2];
  logic [31:0] wd [2];
  int          last_g;
  int          tmo_m;

  // Expected outputs for the current cycle
  logic [1:0]  e_done;
  logic        e_sel, e_en, e_busy, e_write, e_err;
  logic [15:0] e_addr;
  logic [31:0] e_wdata, e_rdata;
  bit          e_apb, e_rsp;

  // Observations for the directed literal checks
  int          acc_seen;
  logic [1:0]  obs_done;
  logic [31:0] obs_rdata, obs_wd;
  logic        obs_err;
  int          win;
  int          order [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string ph);
    chk({ph, ".done"}, 32'(req_done), 32'(e_done));
    chk({ph, ".selx"}, 32'(apb_selx), 32'(e_sel));
    chk({ph, ".enable"}, 32'(apb_enable), 32'(e_en));
    chk({ph, ".busy"}, 32'(busy), 32'(e_busy));
    chk({ph, ".tmo_cnt"}, 32'(tmo_cnt), 32'(tmo_m));
    if (e_apb) begin
      chk({ph, ".addr"}, 32'(apb_addr), 32'(e_addr));
      chk({ph, ".write"}, 32'(apb_write), 32'(e_write));
      chk({ph, ".wdata"}, apb_wdata, e_wdata);
    end
    if (e_rsp) begin
      chk({ph, ".rdata"}, req_rdata, e_rdata);
      chk({ph, ".err"}, 32'(req_err), 32'(e_err));
    end
  endtask

  task automatic drive_reqs();
    req_valid = pend;
    req_addr  = {a[1], a[0]};
    req_write = {w[1], w[0]};
    req_wdata = {wd[1], wd[0]};
  endtask

  task automatic new_req(input int r);
    pend[r] = 1'b1;
    a[r]    = 16'($urandom);
    w[r]    = 1'($urandom);
    wd[r]   = $urandom;
  endtask

  task automatic set_idle_exp();
    e_done = 2'b00; e_sel = 1'b0; e_en = 1'b0; e_busy = 1'b0;
    e_apb = 1'b0; e_rsp = 1'b0;
  endtask

  // One complete transfer; the DUT must be idle with requests already driven.
  task automatic xfer(input int waits, input logic [31:0] rd, input logic err_in,
                      input bit noise, output int winner);
    bit timed;
    int nacc;
    int o;
    winner = (pend == 2'b11) ? ((last_g == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
    last_g = winner;
    o      = 1 - winner;
    timed  = (waits >= TIMEOUT);
    nacc   = timed ? TIMEOUT : waits + 1;
    acc_seen = 0;
    apb_ready = noise ? 1'($urandom) : 1'b0;
    tick();
    e_done = 2'b00; e_sel = 1'b1; e_en = 1'b0; e_busy = 1'b1;
    e_apb = 1'b1; e_rsp = 1'b0;
    e_addr = a[winner]; e_write = w[winner]; e_wdata = wd[winner];
    compare("setup");
    obs_wd = apb_wdata;
    if (noise && !pend[o] && ($urandom_range(0, 1) == 1)) begin
      new_req(o);
      drive_reqs();
    end
    for (int i = 0; i < nacc; i++) begin
      tick();
      e_en = 1'b1;
      compare("access");
      if (apb_enable) acc_seen++;
      apb_ready  = (!timed && i == waits);
      apb_rdata  = (!timed && i == waits) ? rd : $urandom;
      apb_slverr = (!timed && i == waits) ? err_in : 1'($urandom);
    end
    tick();
    e_done  = (winner == 1) ? 2'b10 : 2'b01;
    e_sel   = 1'b0; e_en = 1'b0; e_apb = 1'b0; e_rsp = 1'b1;
    e_rdata = (timed || w[winner]) ? 32'h0 : rd;
    e_err   = timed ? 1'b1 : err_in;
    if (timed && tmo_m < 255) tmo_m++;
    compare("done");
    obs_done = req_done; obs_rdata = req_rdata; obs_err = req_err;
    apb_ready = 1'b0;
    pend[winner] = 1'b0;
    drive_reqs();
    tick();
    set_idle_exp();
    compare("idle");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend = 2'b00;
    drive_reqs();
    apb_ready = 1'b0;
    last_g = 1;
    tmo_m = 0;
    tick();
    set_idle_exp();
    compare("reset");
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    int k;
    rst_n = 1'b0;
    pend = 2'b00;
    for (int r = 0; r < 2; r++) begin
      a[r] = 16'd0; w[r] = 1'b0; wd[r] = 32'd0;
    end
    drive_reqs();
    apb_ready = 1'b0; apb_rdata = 32'd0; apb_slverr = 1'b0;
    last_g = 1; tmo_m = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.done", 32'(req_done), 32'd0);
    chk("rst.selx", 32'(apb_selx), 32'd0);
    chk("rst.enable", 32'(apb_enable), 32'd0);
    chk("rst.write", 32'(apb_write), 32'd0);
    chk("rst.err", 32'(req_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.addr", 32'(apb_addr), 32'd0);
    chk("rst.wdata", apb_wdata, 32'd0);
    chk("rst.rdata", req_rdata, 32'd0);
    chk("rst.tmo_cnt", 32'(tmo_cnt), 32'd0);
    #3 rst_n = 1'b1;

    // r0 read with one wait cycle
    pend = 2'b01; a[0] = 16'h0000; w[0] = 1'b0; wd[0] = 32'd0;
    drive_reqs();
    xfer(1, 32'h20240101, 1'b0, 1'b0, win);
    chk("t037.winner", 32'(win), 32'd0);
    chk("t037.done", 32'(obs_done), 32'd1);
    chk("t037.rdata", obs_rdata, 32'h20240101);
    chk("t037.err", 32'(obs_err), 32'd0);
    chk("t037.access_cycles", 32'(acc_seen), 32'd2);

    // r1 write: read data must come back as zero
    pend = 2'b10; a[1] = 16'h0004; w[1] = 1'b1; wd[1] = 32'hDEADBEEF;
    drive_reqs();
    xfer(0, 32'h12345678, 1'b0, 1'b0, win);
    chk("t039.done", 32'(obs_done), 32'd2);
    chk("t039.wdata", obs_wd, 32'hDEADBEEF);
    chk("t039.rdata", obs_rdata, 32'd0);

    // slave never ready
    pend = 2'b01; a[0] = 16'h0010; w[0] = 1'b0;
    drive_reqs();
    xfer(TIMEOUT, 32'hFFFFFFFF, 1'b0, 1'b0, win);
    chk("t040.access_cycles", 32'(acc_seen), 32'd16);
    chk("t040.err", 32'(obs_err), 32'd1);
    chk("t040.rdata", obs_rdata, 32'd0);
    chk("t040.tmo_cnt", 32'(tmo_cnt), 32'd1);

    // reset in the middle of ACCESS
    pend = 2'b01; a[0] = 16'h0020; w[0] = 1'b0;
    drive_reqs();
    apb_ready = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t041.selx", 32'(apb_selx), 32'd0);
    chk("t041.enable", 32'(apb_enable), 32'd0);
    chk("t041.busy", 32'(busy), 32'd0);
    chk("t041.done", 32'(req_done), 32'd0);
    chk("t041.tmo_cnt", 32'(tmo_cnt), 32'd0);
    pend = 2'b00; drive_reqs();
    last_g = 1; tmo_m = 0;
    tick();
    chk("t041.no_done", 32'(req_done), 32'd0);
    #3 rst_n = 1'b1;
    new_req(0);
    drive_reqs();
    xfer(2, 32'hCAFE0001, 1'b0, 1'b0, win);
    chk("t041.after_done", 32'(obs_done), 32'd1);

    // repeated ties alternate starting with r0
    do_reset();
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < 2; r++) if (!pend[r]) new_req(r);
      drive_reqs();
      xfer(0, $urandom, 1'b0, 1'b0, win);
      order[n] = win;
      chk("t038.done", 32'(obs_done), (n % 2 == 1) ? 32'd2 : 32'd1);
    end
    chk("t038.model0", 32'(order[0]), 32'd0);
    chk("t038.model1", 32'(order[1]), 32'd1);
    chk("t038.model2", 32'(order[2]), 32'd0);
    chk("t038.model3", 32'(order[3]), 32'd1);

    // random traffic
    for (int t = 0; t < 120; t++) begin
      for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(0, 2) != 0) new_req(r);
      drive_reqs();
      if (pend == 2'b00) begin
        tick();
        set_idle_exp();
        compare("idle_wait");
      end else begin
        k = int'($urandom_range(0, 9));
        if (k < 6) waits = 0;
        else if (k < 9) waits = int'($urandom_range(1, 4));
        else waits = TIMEOUT + int'($urandom_range(0, 2));
        xfer(waits, $urandom, 1'($urandom_range(0, 3) == 0), 1'b1, win);
      end
    end

    // tmo_cnt saturation
    for (int t = 0; t < 260; t++) begin
      if (pend == 2'b00) new_req(0);
      drive_reqs();
      xfer(TIMEOUT, $urandom, 1'b0, 1'b0, win);
    end
    chk("sat.model", 32'(tmo_m), 32'd255);
    chk("sat.tmo_cnt", 32'(tmo_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
